i2s_xmit: RTL and testbench
===========================

# i2s_xmit

Serial I2S transmitter that is the transmit-side companion of the codec I2S receiver. It accepts one parallel {Left,Right} frame at a time from the xclk-domain sample path through a valid/ack handshake, buffers it, and shifts it out MSB-first on `dout`. Shifting is synchronised to codec-supplied BCLK/LRCLK, which are asynchronous to xclk. It drives the codec DAC data pin on the same BCLK/LRCLK pair the receiver samples.

## Interface
- DATA_BITS, 32, size of {Left,Right} frame; must be even; DS = DATA_BITS/2
- BCNT, 1, BCLK falling edges after an LRCLK edge before the channel MSB is driven (1 = I2S, 0 = left-justified)
- xclk  in  1  system clock; all logic on posedge
- xrst_n  in  1  asynchronous, active-low reset
- BCLK  in  1  codec bit clock, not in xclk domain
- LRCLK  in  1  codec frame clock, not in xclk domain; low = left
- xData  in  DATA_BITS  {Left,Right} frame; Left in [DATA_BITS-1:DS]
- xData_valid  in  1  frame offered; held until acked
- xData_ack  out  1  one-xclk pulse, frame accepted into the holding register
- xUnderrun  out  1  one-xclk pulse, frame start with the holding register empty
- dout  out  1  serial data to codec, registered

## Operation
- **Synchronisers:** BCLK and LRCLK each pass through three xclk flops.
  - Edges are detected between stages 2 and 3: xBfall = !s2 & s3, xLRfall = !s2 & s3, xLRrise = s2 & !s3.
- **Holding register (one entry), `hold_full` flag:**
  - If xData_valid & !hold_full: load xData, set hold_full, pulse xData_ack next cycle.
  - If valid while full: ignore, no ack; the producer keeps valid.
- **Frame start (xLRfall):**
  - If hold_full: shift register <= hold; hold_full cleared.
  - Else: pulse xUnderrun; see Configuration for the underrun fill value.
  - A load and a transfer in the same cycle: the transfer uses the old content, hold_full stays set that cycle, and the new load happens the next cycle.
- **Bit counter `n`:** width clogb2(DS+BCNT+1).
  - Set to 0 on xLRfall or xLRrise.
  - Incremented on each other xBfall.
  - Saturates at all-ones.
- **Driving dout on xBfall** (including an xBfall coincident with an LR edge, which is n = 0):
  - n < BCNT: dout holds its value (previous channel LSB).
  - BCNT ≤ n < BCNT+DS: dout = bit DS-1-(n-BCNT) of the current channel; the left half applies while synchronised LRCLK is low, the right half while it is high.
  - n ≥ BCNT+DS: dout = 0.
- **Right half:** uses the shift register's lower half captured at the preceding xLRfall. There is no reload at xLRrise.
- **First LR edge after reset is xLRrise:** right half outputs zeros, because the shift register is reset to 0.

## Timing
- **Reset values:** dout=0, xData_ack=0, xUnderrun=0, hold_full=0, shift register=0, n=all-ones.
- All synchroniser flops reset to 0.
- **Reset assertion mid-frame:** dout goes to 0 immediately. After release, output stays 0 until the first xLRfall.
- **Edge latency:** a pin edge is detected 3 xclk cycles after it is first sampled.
- **dout latency:** dout updates 1 xclk after the detecting cycle, i.e. about 4 xclk after the BCLK fall.
- **Ack latency:** xData_ack is asserted 1 xclk after an accepted valid.
- **Underrun timing:** xUnderrun is asserted 1 xclk after the xLRfall detection.
- **Clock ratio:** xclk ≥ 4× BCLK is required so every BCLK level spans at least 2 xclk. Behaviour below this ratio is undefined.
- **Throughput:** one frame per LRCLK period. The producer may present the next frame any time after the ack.

## Configuration
- `I2S_XMIT_REPEAT_EN` defined: on underrun, the shift register is reloaded with the last transferred frame (repeat last sample). Requires a DATA_BITS-wide last-frame register, reset to 0.
- Not defined: on underrun, the shift register is loaded with 0 (silence).
- xUnderrun pulses in both builds.

## Test plan
- **Basic I2S frame.** Config: DATA_BITS=32, BCNT=1, xclk=8×BCLK. Load 0xA5A5_3C3C before the first LR fall.
  - dout = 1010_0101_1010_0101 starting the 2nd BCLK fall after the LR fall.
  - dout = 0011_1100_0011_1100 after the LR rise.
  - One ack, no underrun.
- **Left-justified frame (BCNT=0), same data:** MSB 0xA driven on the BCLK fall coincident with the LR edge.
- **Back-pressure.**
  - Stimulus: valid held with hold_full set.
  - Required: no ack until the next xLRfall transfer, ack exactly 1 cycle after the load, frames are not dropped or duplicated over 4 frames.
- **Underrun.**
  - Stimulus: no valid before an LR fall after frame 0x1234_5678.
  - Required: xUnderrun pulse. Without the macro dout is all-zero for the frame; with `I2S_XMIT_REPEAT_EN` it repeats 0x1234_5678.
- **Coincident transfer and load.**
  - Stimulus: valid asserted in the same cycle as the xLRfall transfer with hold_full=1.
  - Required: old frame shifted, new frame loaded the next cycle, ack exactly once.
- **Reset mid-frame.**
  - Stimulus: xrst_n low during the left half.
  - Required: dout=0 immediately, no ack/underrun during reset, output resumes only at the first xLRfall after release.

Source files
------------

// File: rtl/i2s_xmit.sv
// I2S transmitter: buffers one {Left,Right} frame from xclk side, shifts it MSB-first on dout against codec BCLK/LRCLK.
// Latency: pin edges act 3 xclk after first sampling; dout, xData_ack and xUnderrun are registered (1 xclk after the deciding cycle).
// Backpressure: one-entry holding register; while it is full xData_valid is ignored (no ack) and the producer keeps it asserted.
//
// Ports: xclk / xrst_n      system clock, asynchronous active-low reset
//        BCLK / LRCLK       codec bit and frame clocks, asynchronous to xclk (LRCLK low = left)
//        xData / xData_valid / xData_ack   frame handshake, Left in the upper half
//        xUnderrun          pulse when a frame starts with nothing buffered
//        dout               registered serial data to the codec DAC
// Option: define I2S_XMIT_REPEAT_EN to resend the last transferred frame on underrun instead of silence.
module i2s_xmit #(
    parameter int DATA_BITS = 32,
    parameter int BCNT      = 1
) (
    input  logic                 xclk,
    input  logic                 xrst_n,
    input  logic                 BCLK,
    input  logic                 LRCLK,
    input  logic [DATA_BITS-1:0] xData,
    input  logic                 xData_valid,
    output logic                 xData_ack,
    output logic                 xUnderrun,
    output logic                 dout
);
    localparam int DS = DATA_BITS / 2;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    localparam int            NW    = clogb2(DS + BCNT + 1);
    localparam logic [NW-1:0] N_MAX = '1;

    // Three-flop synchronisers; bit 0 is the first stage.
    logic [2:0] bclk_sync;
    logic [2:0] lrclk_sync;
    logic       x_bfall;
    logic       x_lrfall;
    logic       x_lrrise;
    logic       lr_edge;

    always_ff @(posedge xclk or negedge xrst_n) begin
        if (!xrst_n) begin
            bclk_sync  <= '0;
            lrclk_sync <= '0;
        end else begin
            bclk_sync  <= {bclk_sync[1:0], BCLK};
            lrclk_sync <= {lrclk_sync[1:0], LRCLK};
        end
    end

    assign x_bfall  = !bclk_sync[1] &  bclk_sync[2];
    assign x_lrfall = !lrclk_sync[1] &  lrclk_sync[2];
    assign x_lrrise =  lrclk_sync[1] & !lrclk_sync[2];
    assign lr_edge  = x_lrfall | x_lrrise;

    // Holding register. A transfer needs hold_full, a load needs !hold_full, so the
    // two never collide: a producer waiting on a full register loads the cycle after.
    logic [DATA_BITS-1:0] hold;
    logic                 hold_full;
    logic                 xfer;
    logic                 load;

    assign xfer = x_lrfall & hold_full;
    assign load = xData_valid & !hold_full;

    always_ff @(posedge xclk or negedge xrst_n) begin
        if (!xrst_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
            xData_ack <= 1'b0;
            xUnderrun <= 1'b0;
        end else begin
            xData_ack <= load;
            xUnderrun <= x_lrfall & !hold_full;
            if (xfer) begin
                hold_full <= 1'b0;
            end else if (load) begin
                hold      <= xData;
                hold_full <= 1'b1;
            end
        end
    end

    // Value taken into the shift register at frame start when nothing is buffered.
    logic [DATA_BITS-1:0] fill;
`ifdef I2S_XMIT_REPEAT_EN
    logic [DATA_BITS-1:0] last_frame;

    always_ff @(posedge xclk or negedge xrst_n) begin
        if (!xrst_n) begin
            last_frame <= '0;
        end else if (xfer) begin
            last_frame <= hold;
        end
    end

    assign fill = last_frame;
`else
    assign fill = '0;
`endif

    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] start_val;
    logic [DATA_BITS-1:0] frame;

    assign start_val = hold_full ? hold : fill;
    // On the frame-start cycle the new frame must already drive dout (BCNT=0 sends its MSB there).
    assign frame     = x_lrfall ? start_val : shreg;

    // Bit counter and serial output. dout is chosen from the counter value that this
    // BCLK fall produces: 0 on an LR edge, otherwise the saturating increment.
    logic [NW-1:0] n;
    logic [NW-1:0] n_nxt;
    logic [DS-1:0] chan;
    logic [DS-1:0] chan_sh;
    logic          dout_nxt;
    int            pos;

    always_comb begin
        n_nxt = n;
        if (lr_edge) begin
            n_nxt = '0;
        end else if (x_bfall && (n != N_MAX)) begin
            n_nxt = n + NW'(1);
        end

        pos      = int'(n_nxt) - BCNT;
        chan     = lrclk_sync[1] ? frame[DS-1:0] : frame[DATA_BITS-1:DS];
        chan_sh  = chan << pos;      // only consulted when 0 <= pos < DS
        dout_nxt = dout;
        if (x_bfall) begin
            if (pos >= DS) begin
                dout_nxt = 1'b0;
            end else if (pos >= 0) begin
                dout_nxt = chan_sh[DS-1];
            end
        end
    end

    always_ff @(posedge xclk or negedge xrst_n) begin
        if (!xrst_n) begin
            n     <= N_MAX;
            dout  <= 1'b0;
            shreg <= '0;
        end else begin
            n    <= n_nxt;
            dout <= dout_nxt;
            if (x_lrfall) begin
                shreg <= start_val;
            end
        end
    end
endmodule

// File: tb/tb_i2s_xmit.sv
// Drives an I2S-mode (BCNT=1) and a left-justified (BCNT=0) transmitter from the same
// codec clocks and producer, 20 BCLKs per half frame, xclk = 8x BCLK.
module tb_i2s_xmit;
    logic        xclk;
    logic        xrst_n;
    logic        BCLK;
    logic        LRCLK;
    logic [31:0] xData;
    logic        xData_valid;
    logic        ack1, und1, dout1;
    logic        ack0, und0, dout0;

    i2s_xmit #(.DATA_BITS(32), .BCNT(1)) dut_i2s (
        .xclk(xclk), .xrst_n(xrst_n), .BCLK(BCLK), .LRCLK(LRCLK),
        .xData(xData), .xData_valid(xData_valid),
        .xData_ack(ack1), .xUnderrun(und1), .dout(dout1)
    );

    i2s_xmit #(.DATA_BITS(32), .BCNT(0)) dut_lj (
        .xclk(xclk), .xrst_n(xrst_n), .BCLK(BCLK), .LRCLK(LRCLK),
        .xData(xData), .xData_valid(xData_valid),
        .xData_ack(ack0), .xUnderrun(und0), .dout(dout0)
    );

    initial begin
        xclk = 1'b0;
        forever #5 xclk = ~xclk;
    end

`ifdef I2S_XMIT_REPEAT_EN
    localparam logic [31:0] FILL2 = 32'h1234_5678;
    localparam logic [31:0] FILL7 = 32'hF00F_0FF0;
`else
    localparam logic [31:0] FILL2 = 32'h0;
    localparam logic [31:0] FILL7 = 32'h0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] prod_q[$];
    int   ack_cnt1 = 0, ack_cnt0 = 0, und_cnt1 = 0, und_cnt0 = 0, proto_err = 0;
    logic prev_valid = 1'b0;
    logic prev_ack   = 1'b0;
    int   rs_a1, rs_a0, rs_u1, rs_u0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Producer and handshake monitor, both on the falling xclk edge.
    initial begin
        xData_valid = 1'b0;
        xData       = '0;
        forever begin
            @(negedge xclk);
            if (ack1) ack_cnt1++;
            if (ack0) ack_cnt0++;
            if (und1) und_cnt1++;
            if (und0) und_cnt0++;
            // An ack must follow a cycle with valid high and never last two cycles.
            if (ack1 && (!prev_valid || prev_ack)) proto_err++;
            prev_ack = ack1;
            if (xData_valid && ack1) xData_valid = 1'b0;
            if (!xData_valid && prod_q.size() > 0) begin
                xData       = prod_q.pop_front();
                xData_valid = 1'b1;
            end
            prev_valid = xData_valid;
        end
    end

    // One half frame: 20 BCLK periods with LRCLK at lr. b[k] is dout as driven by fall k,
    // sampled mid-way through the following high phase.
    task automatic drive_half(input logic lr, input int rst_at,
                              output logic [19:0] b1, output logic [19:0] b0);
        b1 = '0;
        b0 = '0;
        for (int k = 0; k < 20; k++) begin
            BCLK  = 1'b0;
            LRCLK = lr;
            #40 BCLK = 1'b1;
            #20;
            b1[k] = dout1;
            b0[k] = dout0;
            if (k == rst_at) begin
                rs_a1 = ack_cnt1; rs_a0 = ack_cnt0; rs_u1 = und_cnt1; rs_u0 = und_cnt0;
                xrst_n = 1'b0;
                #1;
                check("rst_dout_i2s", 32'(dout1), 32'h0);
                check("rst_dout_lj", 32'(dout0), 32'h0);
                #19;
            end else if (rst_at >= 0 && k == rst_at + 3) begin
                check("rst_no_ack", 32'(ack_cnt1 - rs_a1 + ack_cnt0 - rs_a0), 32'h0);
                check("rst_no_und", 32'(und_cnt1 - rs_u1 + und_cnt0 - rs_u0), 32'h0);
                xrst_n = 1'b1;
                #20;
            end else begin
                #20;
            end
        end
    endtask

    function automatic logic [19:0] exp_bits(input logic [15:0] w, input int off);
        logic [19:0] e;
        e = '0;
        for (int j = 0; j < 16; j++) e[off + j] = w[15 - j];
        return e;
    endfunction

    typedef struct {
        int               npush;
        logic [3:0][31:0] push;     // pushed at the start of this row's right half
        logic [31:0]      exp_dat;  // frame expected on dout during this row
        int               exp_ack;
        int               exp_und;
        int               rst_at;   // left-half BCLK index to assert reset, -1 for none
    } vec_t;

    vec_t vt [10];

    initial begin
        logic [19:0] l1, l0, r1, r0;
        int a1, a0, u1, u0;

        vt[0] = '{1, {32'h0, 32'h0, 32'h0, 32'h1234_5678}, 32'hA5A5_3C3C, 1, 0, -1};
        vt[1] = '{0, 128'h0, 32'h1234_5678, 0, 0, -1};
        vt[2] = '{4, {32'hF00F_0FF0, 32'h89AB_CDEF, 32'h0123_4567, 32'hDEAD_BEEF}, FILL2, 1, 1, -1};
        vt[3] = '{0, 128'h0, 32'hDEAD_BEEF, 1, 0, -1};
        vt[4] = '{0, 128'h0, 32'h0123_4567, 1, 0, -1};
        vt[5] = '{0, 128'h0, 32'h89AB_CDEF, 1, 0, -1};
        vt[6] = '{0, 128'h0, 32'hF00F_0FF0, 0, 0, -1};
        vt[7] = '{1, {32'h0, 32'h0, 32'h0, 32'h5A5A_C3C3}, FILL7, 1, 1, -1};
        vt[8] = '{1, {32'h0, 32'h0, 32'h0, 32'h9ABC_DEF0}, 32'h0, 1, 0, 8};
        vt[9] = '{0, 128'h0, 32'h9ABC_DEF0, 0, 0, -1};

        BCLK   = 1'b1;
        LRCLK  = 1'b0;
        xrst_n = 1'b0;
        #27;
        check("reset_dout_i2s", 32'(dout1), 32'h0);
        check("reset_dout_lj", 32'(dout0), 32'h0);
        check("reset_ack", 32'({ack1, ack0}), 32'h0);
        check("reset_und", 32'({und1, und0}), 32'h0);
        xrst_n = 1'b1;

        // Lead-in: the first LR edge after reset is a rise; the right half must be silent.
        prod_q.push_back(32'hA5A5_3C3C);
        drive_half(1'b0, -1, l1, l0);
        drive_half(1'b1, -1, r1, r0);
        check("lead_right_i2s", 32'(r1), 32'h0);
        check("lead_right_lj", 32'(r0), 32'h0);
        check("lead_ack", 32'(ack_cnt1), 32'd1);
        check("lead_und", 32'(und_cnt1 + und_cnt0), 32'h0);

        for (int i = 0; i < 10; i++) begin
            a1 = ack_cnt1; a0 = ack_cnt0; u1 = und_cnt1; u0 = und_cnt0;
            drive_half(1'b0, vt[i].rst_at, l1, l0);
            for (int p = 0; p < vt[i].npush; p++) prod_q.push_back(vt[i].push[p]);
            drive_half(1'b1, -1, r1, r0);

            if (vt[i].rst_at < 0) begin
                check($sformatf("row%0d_left_i2s", i), 32'(l1), 32'(exp_bits(vt[i].exp_dat[31:16], 1)));
                check($sformatf("row%0d_left_lj", i), 32'(l0), 32'(exp_bits(vt[i].exp_dat[31:16], 0)));
            end else begin
                check($sformatf("row%0d_rstleft_i2s", i), 32'(l1 >> (vt[i].rst_at + 1)), 32'h0);
                check($sformatf("row%0d_rstleft_lj", i), 32'(l0 >> (vt[i].rst_at + 1)), 32'h0);
            end
            check($sformatf("row%0d_right_i2s", i), 32'(r1), 32'(exp_bits(vt[i].exp_dat[15:0], 1)));
            check($sformatf("row%0d_right_lj", i), 32'(r0), 32'(exp_bits(vt[i].exp_dat[15:0], 0)));
            check($sformatf("row%0d_ack_i2s", i), 32'(ack_cnt1 - a1), 32'(vt[i].exp_ack));
            check($sformatf("row%0d_ack_lj", i), 32'(ack_cnt0 - a0), 32'(vt[i].exp_ack));
            check($sformatf("row%0d_und_i2s", i), 32'(und_cnt1 - u1), 32'(vt[i].exp_und));
            check($sformatf("row%0d_und_lj", i), 32'(und_cnt0 - u0), 32'(vt[i].exp_und));
        end

        check("ack_protocol", 32'(proto_err), 32'h0);
        check("queue_drained", 32'(prod_q.size()), 32'h0);
        check("valid_idle", 32'(xData_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
